// File: rtl/rca4_divider.sv
// rtl/rca4_divider.sv - sequential unsigned restoring divider, one trial subtraction per clock
module rca4_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH:0]   p_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   t_sum;
  logic [WIDTH:0]   p_d;
  logic [WIDTH-1:0] q_d;

  // One restoring iteration: shift {P,Q}, trial-subtract the divisor as an
  // add of its ones-complement with carry-in 1, keep or restore on the sign.
  always_comb begin
    p_shift = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    t_sum   = p_shift + {1'b1, ~d_q} + {{WIDTH{1'b0}}, 1'b1};
    if (t_sum[WIDTH]) begin
      p_d = p_shift;
      q_d = {q_q[WIDTH-2:0], 1'b0};
    end else begin
      p_d = t_sum;
      q_d = {q_q[WIDTH-2:0], 1'b1};
    end
  end

  // Control FSM plus datapath registers; result registers only move on the
  // edge that enters DONE so they hold across the idle time between operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      p_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            p_q     <= '0;
            q_q     <= dividend;
            d_q     <= divisor;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          p_q   <= p_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            quotient_q  <= q_d;
            remainder_q <= p_d[WIDTH-1:0];
            dbz_q       <= (d_q == '0);
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_rca4_divider.sv
// tb/tb_rca4_divider.sv - self-checking bench for rca4_divider (table, scoreboard, corner sequences)
module tb_rca4_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  logic       start8;
  logic [7:0] dividend8;
  logic [7:0] divisor8;
  logic       busy8;
  logic       done8;
  logic [7:0] quotient8;
  logic [7:0] remainder8;
  logic       dbz8;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] sb[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] eq;
    logic [3:0] er;
    logic       edz;
  } vec_t;

  rca4_divider #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  rca4_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(dividend8), .divisor(divisor8),
    .busy(busy8), .done(done8), .quotient(quotient8), .remainder(remainder8),
    .div_by_zero(dbz8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no operation pending at %0t", $time);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        check("quotient", quotient, e[8:5]);
        check("remainder", remainder, e[4:1]);
        check("div_by_zero", div_by_zero, e[0]);
      end
    end
  end

  task automatic op(input logic [3:0] a, input logic [3:0] b,
                    input logic [3:0] eq, input logic [3:0] er, input logic edz);
    int cyc;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    sb.push_back({eq, er, edz});
    @(negedge clk);
    start = 1'b0;
    dividend = 4'($urandom); divisor = 4'($urandom);
    check("busy_after_accept", busy, 1);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, 5);
    check("busy_in_done", busy, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_cleared", busy, 0);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    vec_t vt[8];
    int   cyc;
    logic [3:0] eq;
    logic [3:0] er;
    logic       edz;

    vt[0] = '{a: 4'd13, b: 4'd4,  eq: 4'd3,  er: 4'd1,  edz: 1'b0};
    vt[1] = '{a: 4'd15, b: 4'd1,  eq: 4'd15, er: 4'd0,  edz: 1'b0};
    vt[2] = '{a: 4'd3,  b: 4'd7,  eq: 4'd0,  er: 4'd3,  edz: 1'b0};
    vt[3] = '{a: 4'd0,  b: 4'd5,  eq: 4'd0,  er: 4'd0,  edz: 1'b0};
    vt[4] = '{a: 4'd9,  b: 4'd0,  eq: 4'd15, er: 4'd9,  edz: 1'b1};
    vt[5] = '{a: 4'd15, b: 4'd15, eq: 4'd1,  er: 4'd0,  edz: 1'b0};
    vt[6] = '{a: 4'd1,  b: 4'd15, eq: 4'd0,  er: 4'd1,  edz: 1'b0};
    vt[7] = '{a: 4'd0,  b: 4'd0,  eq: 4'd15, er: 4'd0,  edz: 1'b1};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    start8 = 1'b0; dividend8 = '0; divisor8 = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) op(vt[i].a, vt[i].b, vt[i].eq, vt[i].er, vt[i].edz);

    // start pulses during RUN and during DONE are ignored
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd4;
    sb.push_back({4'd3, 4'd1, 1'b0});
    @(negedge clk);
    start = 1'b0; dividend = 4'd15; divisor = 4'd5;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("pulse_done_seen", done, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("pulse_busy_idle", busy, 0);
    repeat (8) @(negedge clk);
    check("pulse_busy_stays_low", busy, 0);
    check("pulse_q_held", quotient, 3);
    check("pulse_r_held", remainder, 1);

    // start held high through DONE is taken at the first IDLE edge
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd4;
    sb.push_back({4'd3, 4'd1, 1'b0});
    @(negedge clk);
    dividend = 4'd15; divisor = 4'd5;
    sb.push_back({4'd3, 4'd0, 1'b0});
    wait_done(cyc);
    check("held_first_latency", cyc, 4);
    @(negedge clk);
    check("held_idle_gap", busy, 0);
    check("held_q_before", quotient, 3);
    @(negedge clk);
    start = 1'b0;
    check("held_second_busy", busy, 1);
    check("held_r_before", remainder, 1);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("held_second_latency", cyc, 5);
    @(negedge clk);

    // asynchronous reset after two iterations discards the operation
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_quotient", quotient, 0);
    check("mid_rst_remainder", remainder, 0);
    check("mid_rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    op(4'd14, 4'd3, 4'd4, 4'd2, 1'b0);

    // exhaustive sweep against the arithmetic definition
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          eq = 4'hF; er = 4'(a); edz = 1'b1;
        end else begin
          eq = 4'(a / b); er = 4'(a % b); edz = 1'b0;
        end
        op(4'(a), 4'(b), eq, er, edz);
      end
    end

    // WIDTH=8 spot check
    @(negedge clk);
    start8 = 1'b1; dividend8 = 8'd200; divisor8 = 8'd7;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check("w8_latency", cyc, 9);
    check("w8_quotient", quotient8, 28);
    check("w8_remainder", remainder8, 4);
    check("w8_dbz", dbz8, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
